// File: rtl/node_sequencer.sv
// node_sequencer: mission controller for the soil-monitoring line follower.
// Follows the line, confirms side/cross node markings, stops to take a soil
// probe reading, hands one report word to the Xbee link, then blanks node
// detection for a while so the same marking is never reported twice.
module node_sequencer #(
  parameter int DEBOUNCE = 4,
  parameter int SETTLE   = 1000,
  parameter int TIMEOUT  = 50000,
  parameter int BLANK    = 2000,
  parameter int CNT_W    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic [2:0]  line,
  output logic        probe_req,
  input  logic        probe_done,
  input  logic [12:0] moisture,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] tx_data,
  output logic        AF,
  output logic        AB,
  output logic        BF,
  output logic        BB,
  output logic [7:0]  node_count,
  output logic        busy,
  output logic        timeout_err
);

  // The wait counter counts from 0, so each wait ends on its last index.
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK - 1);
  localparam logic [7:0]       DB_TARGET    = 8'(DEBOUNCE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FOLLOW,
    S_SETTLE,
    S_PROBE,
    S_REPORT,
    S_BLANK
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  waitCnt_q, waitCnt_d;
  logic [7:0]        dbCnt_q, dbCnt_d;
  logic [2:0]        lastLine_q, lastLine_d;
  logic [1:0]        side_q, side_d;
  logic [1:0]        motor_q, motor_d;
  logic              probeReq_q, probeReq_d;
  logic              txValid_q, txValid_d;
  logic [15:0]       txData_q, txData_d;
  logic [7:0]        nodeCount_q, nodeCount_d;
  logic              timeoutErr_q, timeoutErr_d;
  logic              busy_q, busy_d;
  logic [7:0]        dbNext;

  // Line pattern {L,C,R} to forward-drive bits {motor A, motor B}.
  // Node patterns and 101 simply drive straight ahead.
  function automatic logic [1:0] followMap(input logic [2:0] pat);
    logic [1:0] drive;
    case (pat)
      3'b100:  drive = 2'b01;
      3'b001:  drive = 2'b10;
      3'b000:  drive = 2'b00;
      default: drive = 2'b11;
    endcase
    return drive;
  endfunction

  // Side and cross markings are the patterns that light two or more
  // adjacent sensors.
  function automatic logic isNode(input logic [2:0] pat);
    return (pat == 3'b110) || (pat == 3'b011) || (pat == 3'b111);
  endfunction

  // Side code carried in the report word: left side, right side or cross.
  function automatic logic [1:0] sideCode(input logic [2:0] pat);
    logic [1:0] code;
    case (pat)
      3'b110:  code = 2'b01;
      3'b011:  code = 2'b10;
      default: code = 2'b11;
    endcase
    return code;
  endfunction

  // Next-state and next-output decode for the whole controller; a low
  // enable overrides every state and drops any report in flight.
  always_comb begin
    state_d      = state_q;
    waitCnt_d    = waitCnt_q;
    dbCnt_d      = dbCnt_q;
    lastLine_d   = line;
    side_d       = side_q;
    motor_d      = 2'b00;
    probeReq_d   = probeReq_q;
    txValid_d    = txValid_q;
    txData_d     = txData_q;
    nodeCount_d  = nodeCount_q;
    timeoutErr_d = timeoutErr_q;
    dbNext       = 8'd0;

    if (!en) begin
      state_d    = S_IDLE;
      waitCnt_d  = '0;
      dbCnt_d    = 8'd0;
      probeReq_d = 1'b0;
      txValid_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          dbCnt_d = 8'd0;
          state_d = S_FOLLOW;
        end

        S_FOLLOW: begin
          motor_d = followMap(line);
          if (isNode(line)) begin
            // A run only continues while the very same node pattern repeats.
            if ((dbCnt_q != 8'd0) && (line == lastLine_q)) begin
              dbNext = dbCnt_q + 8'd1;
            end else begin
              dbNext = 8'd1;
            end
            dbCnt_d = dbNext;
            if (dbNext >= DB_TARGET) begin
              side_d    = sideCode(line);
              motor_d   = 2'b00;
              waitCnt_d = '0;
              dbCnt_d   = 8'd0;
              state_d   = S_SETTLE;
            end
          end else begin
            dbCnt_d = 8'd0;
          end
        end

        S_SETTLE: begin
          if (waitCnt_q == SETTLE_LAST) begin
            probeReq_d = 1'b1;
            waitCnt_d  = '0;
            state_d    = S_PROBE;
          end else begin
            waitCnt_d = waitCnt_q + CNT_W'(1);
          end
        end

        S_PROBE: begin
          // A completion in the final timeout cycle still counts as success.
          if (probe_done) begin
            txData_d   = {side_q, 1'b0, moisture};
            probeReq_d = 1'b0;
            txValid_d  = 1'b1;
            state_d    = S_REPORT;
          end else if (waitCnt_q == TIMEOUT_LAST) begin
            txData_d     = {side_q, 1'b1, 13'h0000};
            timeoutErr_d = 1'b1;
            probeReq_d   = 1'b0;
            txValid_d    = 1'b1;
            state_d      = S_REPORT;
          end else begin
            waitCnt_d = waitCnt_q + CNT_W'(1);
          end
        end

        S_REPORT: begin
          if (tx_ready) begin
            txValid_d   = 1'b0;
            nodeCount_d = nodeCount_q + 8'd1;
            waitCnt_d   = '0;
            state_d     = S_BLANK;
          end
        end

        S_BLANK: begin
          motor_d = followMap(line);
          dbCnt_d = 8'd0;
          if (waitCnt_q == BLANK_LAST) begin
            waitCnt_d = '0;
            state_d   = S_FOLLOW;
          end else begin
            waitCnt_d = waitCnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d    = S_IDLE;
          probeReq_d = 1'b0;
          txValid_d  = 1'b0;
        end
      endcase
    end

    busy_d = (state_d == S_SETTLE) || (state_d == S_PROBE) ||
             (state_d == S_REPORT) || (state_d == S_BLANK);
  end

  // State and output registers; reset aborts whatever is in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      waitCnt_q    <= '0;
      dbCnt_q      <= 8'd0;
      lastLine_q   <= 3'b000;
      side_q       <= 2'b00;
      motor_q      <= 2'b00;
      probeReq_q   <= 1'b0;
      txValid_q    <= 1'b0;
      txData_q     <= 16'h0000;
      nodeCount_q  <= 8'd0;
      timeoutErr_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      waitCnt_q    <= waitCnt_d;
      dbCnt_q      <= dbCnt_d;
      lastLine_q   <= lastLine_d;
      side_q       <= side_d;
      motor_q      <= motor_d;
      probeReq_q   <= probeReq_d;
      txValid_q    <= txValid_d;
      txData_q     <= txData_d;
      nodeCount_q  <= nodeCount_d;
      timeoutErr_q <= timeoutErr_d;
      busy_q       <= busy_d;
    end
  end

  // Reverse drive is reserved, so the back lines are held low.
  assign AF          = motor_q[1];
  assign AB          = 1'b0;
  assign BF          = motor_q[0];
  assign BB          = 1'b0;
  assign probe_req   = probeReq_q;
  assign tx_valid    = txValid_q;
  assign tx_data     = txData_q;
  assign node_count  = nodeCount_q;
  assign busy        = busy_q;
  assign timeout_err = timeoutErr_q;

endmodule

// File: doc/node_sequencer.md
Name: node_sequencer

Overview:
- Mission controller for the soil-monitoring line follower. Consumes the 3-bit line pattern from the sensor-threshold stage and drives the two-motor H-bridge lines.
- On a confirmed node (side or cross marking), it stops the bot, waits for it to settle, handshakes with the soil probe, and hands one report word to the Xbee transmitter.
- It then resumes line following and ignores node patterns for a blanking window, so the same node is never reported twice.

Parameters:
- DEBOUNCE, 4, consecutive identical node-pattern cycles required to confirm a node (1..255).
- SETTLE, 1000, stopped cycles before probe_req is raised.
- TIMEOUT, 50000, max cycles waiting for probe_done before the probe is abandoned.
- BLANK, 2000, post-node cycles during which node patterns are treated as straight.
- CNT_W, 16, width of the shared wait counter; it must hold max(SETTLE, TIMEOUT, BLANK).

Ports:
- clock, input, 1, system clock; all logic on the rising edge.
- reset, input, 1, synchronous, active-high.
- en, input, 1, run enable; 0 forces stop and return to IDLE.
- line, input, 3, {L,C,R}; 1 = sensor over the line.
- probe_req, output, 1, request a soil measurement.
- probe_done, input, 1, measurement complete; moisture is valid in the same cycle.
- moisture, input, 13, probe reading.
- tx_valid, output, 1, report word valid.
- tx_ready, input, 1, Xbee interface accepts the word.
- tx_data, output, 16, {side[1:0], timeout_flag, moisture_latched[12:0]}.
- AF, AB, BF, BB, output, 1 each, motor A (left) fwd/back and motor B (right) fwd/back.
- node_count, output, 8, nodes reported since reset.
- busy, output, 1, high in any state other than IDLE and FOLLOW.
- timeout_err, output, 1, sticky probe-timeout flag.

Behaviour:
- Reset: state = IDLE; AF = AB = BF = BB = 0; probe_req = 0; tx_valid = 0; tx_data = 0; node_count = 0; timeout_err = 0; counters = 0. A reset in any state aborts the operation immediately with no partial transmit.
- All outputs are registered. Motor lines follow line with a 1-cycle latency.
- Motor codes:
  - fwd = A1010 (AF=1, AB=0, BF=1, BB=0).
  - left = 0010 (A stopped, B forward).
  - right = 1000.
  - stop = 0000.
  - AB and BB are never driven to 1 by this block; reverse is reserved.
- IDLE: motors stop. Go to FOLLOW when en = 1.
- FOLLOW line map:
  - 010 → fwd.
  - 100 → left.
  - 001 → right.
  - 000 → stop (line lost); stay in FOLLOW.
  - 101 → fwd.
  - 110, 011, 111 → fwd and increment the debounce counter.
  - The debounce counter clears whenever the pattern changes or is not a node pattern.
  - When the counter reaches DEBOUNCE: latch side (110 → 01, 011 → 10, 111 → 11), set motors to stop, clear the wait counter, go to SETTLE.
- SETTLE: motors stop. After SETTLE cycles, set probe_req = 1 and go to PROBE.
- PROBE:
  - probe_req is held at 1 until probe_done.
  - On probe_done: latch moisture, timeout_flag = 0, probe_req = 0 on the next edge, go to REPORT.
  - If the wait counter reaches TIMEOUT first: moisture_latched = 0, timeout_flag = 1, timeout_err = 1, probe_req = 0, go to REPORT.
  - probe_done arriving in the same cycle as the timeout takes precedence as a success.
- REPORT:
  - tx_valid = 1 with tx_data stable until the cycle where tx_valid & tx_ready.
  - After that cycle: tx_valid = 0, node_count increments (wraps 255 → 0), clear the wait counter, go to BLANK.
  - No timeout on tx_ready.
- BLANK: line following as in FOLLOW, except node patterns map to fwd and the debounce counter is held at 0. After BLANK cycles, go to FOLLOW.
- en = 0 in any state: on the next edge go to IDLE, motors stop, probe_req = 0, tx_valid = 0. An in-flight report is dropped and node_count is unchanged.
- probe_done outside PROBE is ignored. tx_ready outside REPORT is ignored.
- busy = state ∈ {SETTLE, PROBE, REPORT, BLANK}.

Test Plan:
- Reset, then en = 1, line = 010 → cycle after: AF/AB/BF/BB = 1010; line = 100 → 0010; line = 001 → 1000; line = 000 → 0000; all outputs are 0 during reset.
- Hold line = 110 for 3 cycles, then 010 → no node, busy = 0. Hold 110 for 4 cycles → motors 0000, busy = 1; probe_req rises exactly SETTLE cycles later.
- In PROBE, pulse probe_done with moisture = 13'h0ABC → tx_valid = 1, tx_data = 16'h4ABC. Hold tx_ready = 0 for 5 cycles → data stable. tx_ready = 1 → node_count = 1, BLANK entered; line = 111 in BLANK → 1010, no new node.
- Never assert probe_done → after TIMEOUT cycles tx_data = {side, 1, 13'h0}, timeout_err = 1 (sticky after a later successful node). Also assert probe_done in the exact timeout cycle → success path.
- line = 011 node, deassert en during PROBE → next cycle IDLE, probe_req = 0, motors 0000, no tx_valid, node_count unchanged. Repeat with reset asserted mid-REPORT → all outputs at reset values.
- Run 256 complete nodes → node_count wraps to 0; side field = 10 for 011 and 11 for 111.
